// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;

   typedef enum logic {GNT_IF, GNT_D} grant_t;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants that bypassed a pending fetch.
module arb_starve_ctr #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic limit_c
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] cnt;

   // clear wins over increment; increment stops at the limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CW'(STARVE_LIMIT))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign limit_c = (cnt == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-ported memory with req/ack handshake.
// Optional bus watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_done,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_done,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    bus_err
);

   if (STARVE_LIMIT == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
   end

   arb_state_t state;
   grant_t     gnt;
   logic       take;
   logic       starve_limit;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wdog;
`endif

   // data wins unless fetch has been bypassed STARVE_LIMIT times in a row
   assign gnt  = (d_req && !(if_req && starve_limit)) ? GNT_D : GNT_IF;
   assign take = (state == IDLE) && (d_req || if_req);

   arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk     (clk),
      .rst     (rst),
      .inc     (take && (gnt == GNT_D) && if_req),
      .clr     (take && (gnt == GNT_IF)),
      .limit_c (starve_limit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         bus_err   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         wdog      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  mem_req <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                  wdog    <= '0;
`endif
                  if (gnt == GNT_D) begin
                     mem_addr  <= d_addr;
                     mem_we    <= d_we;
                     mem_wdata <= d_wdata;
                     mem_wstrb <= d_we ? d_wstrb : '0;
                     state     <= BUSY_D;
                  end else begin
                     mem_addr  <= if_addr;
                     mem_we    <= 1'b0;
                     mem_wdata <= '0;
                     mem_wstrb <= '0;
                     state     <= BUSY_I;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= RESP;
                  if (state == BUSY_I) begin
                     if_rdata <= mem_rdata;
                     if_done  <= 1'b1;
                  end else begin
                     if (!mem_we) d_rdata <= mem_rdata;
                     d_done <= 1'b1;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               // abort after TIMEOUT_CYCLES busy cycles with no ack
               else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= RESP;
                  if (state == BUSY_I) begin
                     if_rdata <= DATA_WIDTH'(ERR_RDATA);
                     if_done  <= 1'b1;
                  end else begin
                     if (!mem_we) d_rdata <= DATA_WIDTH'(ERR_RDATA);
                     d_done <= 1'b1;
                  end
               end else begin
                  wdog <= wdog + WD_W'(1);
               end
`endif
            end
            RESP: begin
               if_done <= 1'b0;
               d_done  <= 1'b0;
               bus_err <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch and the load/store path, as a step toward a multi-cycle core.
- Arbitrates between the two requesters and sequences a variable-latency req/ack memory transaction.
- Returns read data with a one-cycle done pulse.
- Data accesses win conflicts; a starvation counter guarantees fetch progress.

Parameters:
- DATA_WIDTH, 32, memory and requester data width.
- ADDR_WIDTH, 32, byte address width.
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced; must be >= 1.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req.
- if_rdata  out  DATA_WIDTH  fetched instruction, valid when if_done.
- if_done  out  1  one-cycle completion pulse.
- d_req  in  1  data request, level; held until d_done.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_wstrb  in  DATA_WIDTH/8  store byte enables.
- d_rdata  out  DATA_WIDTH  load data, valid when d_done.
- d_done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wstrb  out  DATA_WIDTH/8  byte enables; all zero for reads.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read data.
- bus_err  out  1  timeout flag, pulses with done; tied 0 without the macro.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, starve_cnt=0.
  - mem_req, mem_we, if_done, d_done and bus_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, if_rdata and d_rdata = 0.
  - Reset mid-transaction abandons it; no done pulse is issued.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- IDLE, requests are sampled only here:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both, with starve_cnt < STARVE_LIMIT -> BUSY_D.
  - Both, with starve_cnt == STARVE_LIMIT -> BUSY_I.
  - Neither -> stay in IDLE.
  - On the transition edge, mem_req=1 and mem_addr, mem_we, mem_wdata and mem_wstrb are loaded from the winner. A fetch loads mem_we=0 and mem_wstrb=0.
- BUSY_x: mem_* held stable until mem_ack is sampled high. On that edge:
  - mem_req=0, mem_we=0.
  - For a read, mem_rdata is captured into if_rdata or d_rdata.
  - The matching done is set to 1 and state -> RESP.
- RESP:
  - done is high for exactly this cycle.
  - The requester must drop or re-present req by the end of RESP.
  - Next state is IDLE.
- Latency: IDLE sample -> mem_req in cycle 1. mem_ack in cycle k -> done in cycle k+1. Minimum req-to-done is 3 cycles. Back-to-back throughput is 1 transaction per 4 cycles at zero memory wait.
- Store: d_rdata is not updated and keeps its last load value.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each data grant made while if_req=1.
  - Clears on every fetch grant.
  - Unchanged otherwise.
- mem_ack outside BUSY_x is ignored.
- A requester dropping req while in BUSY_x has no effect; the transaction completes.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A watchdog counts cycles in BUSY_x.
  - Reaching TIMEOUT_CYCLES without mem_ack aborts the transaction: mem_req=0, state -> RESP.
  - The done pulse is issued with rdata = 32'hDEAD_BEEF (read only) and bus_err=1 for that cycle.
  - The watchdog clears on entry to BUSY_x.
- Undefined: no watchdog; bus_err is constant 0; BUSY_x waits indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, BUSY_I, BUSY_D, RESP}.
  - typedef enum grant_t {GNT_IF, GNT_D}.
  - localparam ERR_RDATA = 32'hDEAD_BEEF.
- One sub-module: arb_starve_ctr (saturating counter with inc, clr, limit-reached output), parameterised by STARVE_LIMIT.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010, mem_ack in the cycle after mem_req with mem_rdata=0x0050_0093 -> mem_addr=0x10, mem_we=0; if_done pulses once 3 cycles after the request with if_rdata=0x0050_0093.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xA5A5_A5A5, d_wstrb=4'hF, 2-cycle ack delay -> mem_we=1 with those values held 2 cycles; d_done pulses; d_rdata unchanged.
- Conflict: if_req and d_req both held continuously, STARVE_LIMIT=4, ack immediate -> grant order D,D,D,D,I,D,D,D,D,I.
- Async reset while in BUSY_D with mem_req=1 -> mem_req drops immediately with no clock edge; no d_done; first grant after release behaves as from reset.
- Spurious mem_ack=1 in IDLE and in RESP -> no state change, no extra done pulse.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, d_req load, mem_ack never asserted -> mem_req low after 8 BUSY cycles; d_done=1, bus_err=1, d_rdata=0xDEAD_BEEF for one cycle.
